// File: rtl/upd7800_bus_responder_if.sv
// uPD7800 external-bus bundle between the CPU/system side (master) and the bus responder (slave).
// Carries the CPU bus, the ROM req/ack port, the I/O register port and status outputs.
interface upd7800_bus_responder_if #(
  parameter int unsigned ROM_AW = 15
);
  logic              CP1_POSEDGE;
  logic              CP2_NEGEDGE;
  logic [15:0]       A;
  logic [7:0]        DB_O;
  logic              DB_OE;
  logic              M1;
  logic [7:0]        DB_I;
  logic              WAIT;
  logic              ROM_REQ;
  logic [ROM_AW-1:0] ROM_ADDR;
  logic              ROM_ACK;
  logic [7:0]        ROM_DATA;
  logic              IO_WR;
  logic              IO_RD;
  logic [7:0]        IO_ADDR;
  logic [7:0]        IO_WDATA;
  logic [7:0]        IO_RDATA;
  logic [15:0]       M1_COUNT;
  logic              BUS_ERR;

  modport master (
    output CP1_POSEDGE, CP2_NEGEDGE, A, DB_O, DB_OE, M1, ROM_ACK, ROM_DATA, IO_RDATA,
    input  DB_I, WAIT, ROM_REQ, ROM_ADDR, IO_WR, IO_RD, IO_ADDR, IO_WDATA, M1_COUNT, BUS_ERR
  );

  modport slave (
    input  CP1_POSEDGE, CP2_NEGEDGE, A, DB_O, DB_OE, M1, ROM_ACK, ROM_DATA, IO_RDATA,
    output DB_I, WAIT, ROM_REQ, ROM_ADDR, IO_WR, IO_RD, IO_ADDR, IO_WDATA, M1_COUNT, BUS_ERR
  );
endinterface

// File: rtl/upd7800_bus_responder.sv
// Target end of the uPD7800 external bus: on-chip RAM, req/ack-backed ROM and an I/O page,
// with WAIT held while read data is outstanding.
module upd7800_bus_responder #(
  parameter logic [15:0] RAM_BASE = 16'hFF80,
  parameter int unsigned RAM_AW   = 7,
  parameter int unsigned ROM_AW   = 15,
  parameter logic [7:0]  IO_PAGE  = 8'hE0,
  parameter logic [7:0]  TIMEOUT  = 8'd200
) (
  input logic                    CLK,
  input logic                    RESETB,
  upd7800_bus_responder_if.slave bus
);

  localparam int unsigned RamDepth = 2 ** RAM_AW;
  localparam logic [16:0] RomLimit = 17'd1 << ROM_AW;

  typedef enum logic [2:0] {
    StIdle, StDecode, StRam, StRomWait, StIo, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        db_i_q, db_i_d;
  logic              rom_req_q, rom_req_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              io_wr_q, io_wr_d;
  logic              io_rd_q, io_rd_d;
  logic [7:0]        io_addr_q, io_addr_d;
  logic [7:0]        io_wdata_q, io_wdata_d;
  logic              io_cap_q, io_cap_d;
  logic [15:0]       m1_count_q, m1_count_d;
  logic              bus_err_q, bus_err_d;
  logic [7:0]        timer_q, timer_d;

  logic [7:0]        ram_q [RamDepth];
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;

  logic ram_hit, io_hit, rom_hit, rom_rd_dec;
  logic hold_cpu, start, strobe_err;

  // Decode uses the live bus: the CPU address register is stable during DECODE.
  assign ram_hit    = bus.A >= RAM_BASE;
  assign io_hit     = bus.A[15:8] == IO_PAGE;
  assign rom_hit    = {1'b0, bus.A} < RomLimit;
  assign ram_idx    = RAM_AW'(bus.A - RAM_BASE);
  assign rom_rd_dec = (state_q == StDecode) && !ram_hit && !io_hit && rom_hit && !bus.DB_OE;

  assign hold_cpu   = rom_rd_dec || (state_q == StRomWait) || ((state_q == StIo) && io_rd_q);
  // Any strobe while low WAIT starts a new cycle, so back-to-back one-CLK cycles are allowed.
  assign start      = bus.CP1_POSEDGE && !hold_cpu;
  assign strobe_err = (bus.CP1_POSEDGE || bus.CP2_NEGEDGE) && hold_cpu;

  always_comb begin
    state_d    = state_q;
    db_i_d     = db_i_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    io_wr_d    = 1'b0;
    io_rd_d    = 1'b0;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_cap_d   = 1'b0;
    m1_count_d = m1_count_q;
    bus_err_d  = bus_err_q;
    timer_d    = timer_q;
    ram_we     = 1'b0;

    if (io_cap_q) db_i_d = bus.IO_RDATA;

    unique case (state_q)
      StIdle, StDone: begin
      end
      StDecode: begin
        if (bus.M1) m1_count_d = m1_count_q + 16'd1;
        if (ram_hit) begin
          if (bus.DB_OE) ram_we = 1'b1;
          else           db_i_d = ram_q[ram_idx];
          state_d = StRam;
        end else if (io_hit) begin
          io_addr_d = bus.A[7:0];
          if (bus.DB_OE) begin
            io_wr_d    = 1'b1;
            io_wdata_d = bus.DB_O;
          end else begin
            io_rd_d = 1'b1;
          end
          state_d = StIo;
        end else if (rom_hit) begin
          if (!bus.DB_OE) begin
            rom_req_d  = 1'b1;
            rom_addr_d = bus.A[ROM_AW-1:0];
            timer_d    = 8'd1;
            state_d    = StRomWait;
          end else begin
            state_d = StDone;
          end
        end else begin
          if (!bus.DB_OE) db_i_d = 8'hFF;
          state_d = StDone;
        end
      end
      StRam: state_d = StDone;
      StRomWait: begin
        // timer_q counts WAIT CLKs including DECODE, so WAIT spans at most TIMEOUT CLKs.
        if (bus.ROM_ACK) begin
          db_i_d    = bus.ROM_DATA;
          rom_req_d = 1'b0;
          state_d   = StDone;
        end else if (timer_q >= TIMEOUT - 8'd1) begin
          db_i_d    = 8'hFF;
          rom_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StIo: begin
        io_cap_d = io_rd_q;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (strobe_err) bus_err_d = 1'b1;
    if (start)      state_d   = StDecode;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q    <= StIdle;
      db_i_q     <= 8'hFF;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
      io_wr_q    <= 1'b0;
      io_rd_q    <= 1'b0;
      io_addr_q  <= 8'h00;
      io_wdata_q <= 8'h00;
      io_cap_q   <= 1'b0;
      m1_count_q <= 16'h0000;
      bus_err_q  <= 1'b0;
      timer_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      db_i_q     <= db_i_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      io_wr_q    <= io_wr_d;
      io_rd_q    <= io_rd_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      io_cap_q   <= io_cap_d;
      m1_count_q <= m1_count_d;
      bus_err_q  <= bus_err_d;
      timer_q    <= timer_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge CLK) begin
    if (ram_we) ram_q[ram_idx] <= bus.DB_O;
  end

  assign bus.DB_I     = db_i_q;
  assign bus.WAIT     = hold_cpu;
  assign bus.ROM_REQ  = rom_req_q;
  assign bus.ROM_ADDR = rom_addr_q;
  assign bus.IO_WR    = io_wr_q;
  assign bus.IO_RD    = io_rd_q;
  assign bus.IO_ADDR  = io_addr_q;
  assign bus.IO_WDATA = io_wdata_q;
  assign bus.M1_COUNT = m1_count_q;
  assign bus.BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_upd7800_bus_responder.sv
// Bench for upd7800_bus_responder: directed bus cycles, read data scored at each CP2 strobe
// against a queue of expected values.
module tb_upd7800_bus_responder;

  localparam int unsigned RomAw = 15;

  logic CLK = 1'b0;
  logic RESETB;
  always #5 CLK = ~CLK;

  upd7800_bus_responder_if #(.ROM_AW(RomAw)) bus ();

  upd7800_bus_responder #(
    .RAM_BASE(16'hFF80),
    .RAM_AW  (7),
    .ROM_AW  (RomAw),
    .IO_PAGE (8'hE0),
    .TIMEOUT (8'd200)
  ) dut (
    .CLK   (CLK),
    .RESETB(RESETB),
    .bus   (bus.slave)
  );

  typedef struct {
    string      name;
    logic [7:0] db;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  int         io_wr_cnt = 0;
  logic [7:0] io_wr_addr = 8'h00;
  logic [7:0] io_wr_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // I/O register model: returns ~index the CLK after IO_RD.
  always @(posedge CLK or negedge RESETB) begin
    if (!RESETB)         bus.IO_RDATA <= 8'h00;
    else if (bus.IO_RD)  bus.IO_RDATA <= ~bus.IO_ADDR;
  end

  always @(negedge CLK) begin
    if (bus.IO_WR === 1'b1) begin
      io_wr_cnt++;
      io_wr_addr = bus.IO_ADDR;
      io_wr_data = bus.IO_WDATA;
    end
  end

  // Scoreboard monitor: CPU samples DB_I at CP2.
  always @(posedge CLK) begin
    exp_t e;
    if (bus.CP2_NEGEDGE === 1'b1) begin
      #1;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_cp2", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check(e.name, 32'(bus.DB_I), 32'(e.db));
        check({e.name, "_wait_at_cp2"}, 32'(bus.WAIT), 32'd0);
      end
    end
  end

  task automatic bus_cycle(input logic [15:0] addr, input logic we, input logic [7:0] wdata,
                           input logic m1, input int ack_at, input logic [7:0] ack_data,
                           input string name, input logic [7:0] exp_db, output int wait_cycles);
    int   req_cycles = 0;
    int   guard = 0;
    exp_t e;
    wait_cycles = 0;
    if (!we) begin
      e.name = name;
      e.db   = exp_db;
      sb_q.push_back(e);
    end
    @(negedge CLK);
    bus.A = addr; bus.DB_O = wdata; bus.DB_OE = we; bus.M1 = m1; bus.CP1_POSEDGE = 1'b1;
    @(negedge CLK);
    bus.CP1_POSEDGE = 1'b0;
    while (bus.WAIT === 1'b1 && guard < 1000) begin
      wait_cycles++;
      guard++;
      if (bus.ROM_REQ === 1'b1) req_cycles++;
      bus.ROM_ACK  = (ack_at != 0) && (req_cycles == ack_at);
      bus.ROM_DATA = ack_data;
      @(negedge CLK);
    end
    bus.ROM_ACK = 1'b0;
    bus.M1      = 1'b0;
    check({name, "_wait_bound"}, 32'(guard < 1000), 32'd1);
    repeat (3) @(negedge CLK);
    if (!we) begin
      bus.CP2_NEGEDGE = 1'b1;
      @(negedge CLK);
      bus.CP2_NEGEDGE = 1'b0;
    end
  endtask

  task automatic m1_burst(input int n);
    @(negedge CLK);
    bus.A = 16'h9000; bus.DB_OE = 1'b0; bus.M1 = 1'b1; bus.CP1_POSEDGE = 1'b1;
    repeat (n) @(negedge CLK);
    bus.CP1_POSEDGE = 1'b0;
    @(negedge CLK);
    bus.M1 = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wr_before;
    RESETB = 1'b0;
    bus.CP1_POSEDGE = 1'b0; bus.CP2_NEGEDGE = 1'b0; bus.A = 16'h0000; bus.DB_O = 8'h00;
    bus.DB_OE = 1'b0; bus.M1 = 1'b0; bus.ROM_ACK = 1'b0; bus.ROM_DATA = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_db_i", 32'(bus.DB_I), 32'hFF);
    check("rst_wait", 32'(bus.WAIT), 32'd0);
    check("rst_rom_req", 32'(bus.ROM_REQ), 32'd0);
    check("rst_m1_count", 32'(bus.M1_COUNT), 32'd0);
    check("rst_bus_err", 32'(bus.BUS_ERR), 32'd0);
    RESETB = 1'b1;

    // Stray ACK while idle must be ignored.
    @(negedge CLK); bus.ROM_ACK = 1'b1; bus.ROM_DATA = 8'h3C;
    @(negedge CLK); bus.ROM_ACK = 1'b0;
    @(negedge CLK);
    check("idle_ack_db_i", 32'(bus.DB_I), 32'hFF);
    check("idle_ack_err", 32'(bus.BUS_ERR), 32'd0);

    bus_cycle(16'hFF90, 1'b1, 8'h5A, 1'b0, 0, 8'h00, "ram_wr", 8'h00, w);
    check("ram_wr_wait", 32'(w), 32'd0);
    check("ram_wr_db_i_kept", 32'(bus.DB_I), 32'hFF);
    bus_cycle(16'hFF90, 1'b0, 8'h00, 1'b0, 0, 8'h00, "ram_rd_ff90", 8'h5A, w);
    check("ram_rd_wait", 32'(w), 32'd0);

    bus_cycle(16'h1234, 1'b0, 8'h00, 1'b1, 4, 8'hC3, "rom_rd_1234", 8'hC3, w);
    check("rom_rd_wait_clks", 32'(w), 32'd5);
    check("rom_rd_addr", 32'(bus.ROM_ADDR), 32'h1234);
    check("rom_rd_req_low", 32'(bus.ROM_REQ), 32'd0);
    check("rom_rd_m1_count", 32'(bus.M1_COUNT), 32'd1);
    check("rom_rd_bus_err", 32'(bus.BUS_ERR), 32'd0);

    bus_cycle(16'h0100, 1'b0, 8'h00, 1'b0, 0, 8'h00, "rom_timeout_db_i", 8'hFF, w);
    check("rom_timeout_wait_clks", 32'(w), 32'd200);
    check("rom_timeout_bus_err", 32'(bus.BUS_ERR), 32'd1);
    check("rom_timeout_req_low", 32'(bus.ROM_REQ), 32'd0);

    wr_before = io_wr_cnt;
    bus_cycle(16'hE012, 1'b1, 8'h07, 1'b0, 0, 8'h00, "io_wr", 8'h00, w);
    check("io_wr_pulses", 32'(io_wr_cnt - wr_before), 32'd1);
    check("io_wr_addr", 32'(io_wr_addr), 32'h12);
    check("io_wr_data", 32'(io_wr_data), 32'h07);
    bus_cycle(16'hE034, 1'b0, 8'h00, 1'b0, 0, 8'h00, "io_rd_e034", 8'hCB, w);
    bus_cycle(16'h9000, 1'b0, 8'h00, 1'b0, 0, 8'h00, "unmapped_rd_9000", 8'hFF, w);
    bus_cycle(16'hFFFF, 1'b1, 8'hA6, 1'b0, 0, 8'h00, "ram_wr_top", 8'h00, w);
    bus_cycle(16'hFFFF, 1'b0, 8'h00, 1'b0, 0, 8'h00, "ram_rd_ffff", 8'hA6, w);
    bus_cycle(16'hFF90, 1'b0, 8'h00, 1'b0, 0, 8'h00, "ram_rd_ff90_again", 8'h5A, w);

    m1_burst(65534);
    check("m1_count_ffff", 32'(bus.M1_COUNT), 32'hFFFF);
    m1_burst(1);
    check("m1_count_wrap", 32'(bus.M1_COUNT), 32'h0000);

    RESETB = 1'b0;
    @(negedge CLK);
    check("rst2_bus_err", 32'(bus.BUS_ERR), 32'd0);
    RESETB = 1'b1;
    @(negedge CLK);
    bus.A = 16'h0200; bus.DB_OE = 1'b0; bus.M1 = 1'b0; bus.CP1_POSEDGE = 1'b1;
    @(negedge CLK); bus.CP1_POSEDGE = 1'b0;
    repeat (2) @(negedge CLK);
    check("rw2_wait_high", 32'(bus.WAIT), 32'd1);
    check("rw2_req_high", 32'(bus.ROM_REQ), 32'd1);
    bus.CP1_POSEDGE = 1'b1;
    @(negedge CLK); bus.CP1_POSEDGE = 1'b0;
    check("strobe_in_wait_err", 32'(bus.BUS_ERR), 32'd1);
    check("strobe_in_wait_req", 32'(bus.ROM_REQ), 32'd1);
    RESETB = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.ROM_REQ), 32'd0);
    check("mid_rst_wait", 32'(bus.WAIT), 32'd0);
    @(negedge CLK);
    RESETB = 1'b1; bus.ROM_ACK = 1'b1; bus.ROM_DATA = 8'hAA;
    @(negedge CLK); bus.ROM_ACK = 1'b0;
    @(negedge CLK);
    check("late_ack_db_i", 32'(bus.DB_I), 32'hFF);
    check("late_ack_wait", 32'(bus.WAIT), 32'd0);
    check("late_ack_req", 32'(bus.ROM_REQ), 32'd0);

    repeat (2) @(negedge CLK);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
